// File: rtl/operand_sequencer.sv
// rtl/operand_sequencer.sv - register-file read/write sequencer feeding the ALU (option: OPSEQ_ZERO_REG_EN)
module operand_sequencer #(
    parameter int WORD_SIZE     = 8,
    parameter int REG_ADDR_SIZE = 3,
    parameter int OPCODE_SIZE   = 4
) (
    input  logic                     clock,
    input  logic                     reset_enable,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [OPCODE_SIZE-1:0]   instr_opcode,
    input  logic [REG_ADDR_SIZE-1:0] instr_dst,
    input  logic [REG_ADDR_SIZE-1:0] instr_src1,
    input  logic [REG_ADDR_SIZE-1:0] instr_src2,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [REG_ADDR_SIZE-1:0] wb_dst,
    input  logic [WORD_SIZE-1:0]     wb_data,
    output logic [REG_ADDR_SIZE-1:0] rf_num1,
    output logic [REG_ADDR_SIZE-1:0] rf_num2,
    output logic [WORD_SIZE-1:0]     rf_set_val,
    output logic                     rf_get_enable,
    output logic                     rf_set_enable,
    input  logic [WORD_SIZE-1:0]     rf_out1,
    input  logic [WORD_SIZE-1:0]     rf_out2,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic [OPCODE_SIZE-1:0]   op_opcode,
    output logic [REG_ADDR_SIZE-1:0] op_dst,
    output logic [WORD_SIZE-1:0]     op_a,
    output logic [WORD_SIZE-1:0]     op_b
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_CAPTURE = 2'd2,
        S_ISSUE   = 2'd3
    } state_t;

    state_t                   state_q,     state_d;
    logic [OPCODE_SIZE-1:0]   opcode_q,    opcode_d;
    logic [REG_ADDR_SIZE-1:0] dst_q,       dst_d;
    logic [REG_ADDR_SIZE-1:0] src1_q,      src1_d;
    logic [REG_ADDR_SIZE-1:0] src2_q,      src2_d;
    logic                     op_valid_q,  op_valid_d;
    logic [OPCODE_SIZE-1:0]   op_opcode_q, op_opcode_d;
    logic [REG_ADDR_SIZE-1:0] op_dst_q,    op_dst_d;
    logic [WORD_SIZE-1:0]     op_a_q,      op_a_d;
    logic [WORD_SIZE-1:0]     op_b_q,      op_b_d;

    logic                     wb_fire;
    logic                     wb_writes_rf;
    logic [WORD_SIZE-1:0]     cap_a;
    logic [WORD_SIZE-1:0]     cap_b;

    assign op_valid  = op_valid_q;
    assign op_opcode = op_opcode_q;
    assign op_dst    = op_dst_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;

    // Handshake readiness: writebacks are only held off while the register file is being read.
    always_comb begin
        wb_ready    = (state_q == S_IDLE) || (state_q == S_ISSUE);
        instr_ready = (state_q == S_IDLE) && !wb_valid;
        wb_fire     = wb_ready && wb_valid;
`ifdef OPSEQ_ZERO_REG_EN
        wb_writes_rf = wb_fire && (wb_dst != '0);
        cap_a        = (src1_q == '0) ? '0 : rf_out1;
        cap_b        = (src2_q == '0) ? '0 : rf_out2;
`else
        wb_writes_rf = wb_fire;
        cap_a        = rf_out1;
        cap_b        = rf_out2;
`endif
    end

    // Register-file port mux: a write cycle and a read cycle are mutually exclusive by state.
    always_comb begin
        rf_num1       = '0;
        rf_num2       = '0;
        rf_set_val    = '0;
        rf_get_enable = 1'b0;
        rf_set_enable = 1'b0;
        if (wb_writes_rf) begin
            rf_set_enable = 1'b1;
            rf_num1       = wb_dst;
            rf_set_val    = wb_data;
        end else if (state_q == S_READ) begin
            rf_get_enable = 1'b1;
            rf_num1       = src1_q;
            rf_num2       = src2_q;
        end
    end

    // Next-state and next-output computation for the sequencing FSM.
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        dst_d       = dst_q;
        src1_d      = src1_q;
        src2_d      = src2_q;
        op_valid_d  = op_valid_q;
        op_opcode_d = op_opcode_q;
        op_dst_d    = op_dst_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid && instr_ready) begin
                    opcode_d = instr_opcode;
                    dst_d    = instr_dst;
                    src1_d   = instr_src1;
                    src2_d   = instr_src2;
                    state_d  = S_READ;
                end
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // Read data is registered by the register file, so it is valid in this cycle.
                op_a_d      = cap_a;
                op_b_d      = cap_b;
                op_opcode_d = opcode_q;
                op_dst_d    = dst_q;
                op_valid_d  = 1'b1;
                state_d     = S_ISSUE;
            end
            S_ISSUE: begin
                if (op_ready) begin
                    op_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered ALU outputs; reset discards any in-flight instruction.
    always_ff @(posedge clock) begin
        if (reset_enable) begin
            state_q     <= S_IDLE;
            opcode_q    <= '0;
            dst_q       <= '0;
            src1_q      <= '0;
            src2_q      <= '0;
            op_valid_q  <= 1'b0;
            op_opcode_q <= '0;
            op_dst_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            dst_q       <= dst_d;
            src1_q      <= src1_d;
            src2_q      <= src2_d;
            op_valid_q  <= op_valid_d;
            op_opcode_q <= op_opcode_d;
            op_dst_q    <= op_dst_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
        end
    end

endmodule

// File: tb/tb_operand_sequencer.sv
// tb/tb_operand_sequencer.sv - randomized self-checking bench for operand_sequencer
module tb_operand_sequencer;

`ifdef OPSEQ_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_enable;
    logic       instr_valid, instr_ready;
    logic [3:0] instr_opcode;
    logic [2:0] instr_dst, instr_src1, instr_src2;
    logic       wb_valid, wb_ready;
    logic [2:0] wb_dst;
    logic [7:0] wb_data;
    logic [2:0] rf_num1, rf_num2;
    logic [7:0] rf_set_val;
    logic       rf_get_enable, rf_set_enable;
    logic [7:0] rf_out1, rf_out2;
    logic       op_valid, op_ready;
    logic [3:0] op_opcode;
    logic [2:0] op_dst;
    logic [7:0] op_a, op_b;

    int n_pass   = 0;
    int n_checks = 0;
    bit mon_en   = 1'b0;

    always #5 clock = ~clock;

    operand_sequencer #(.WORD_SIZE(8), .REG_ADDR_SIZE(3), .OPCODE_SIZE(4)) dut (
        .clock(clock), .reset_enable(reset_enable),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_opcode(instr_opcode),
        .instr_dst(instr_dst), .instr_src1(instr_src1), .instr_src2(instr_src2),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dst(wb_dst), .wb_data(wb_data),
        .rf_num1(rf_num1), .rf_num2(rf_num2), .rf_set_val(rf_set_val),
        .rf_get_enable(rf_get_enable), .rf_set_enable(rf_set_enable),
        .rf_out1(rf_out1), .rf_out2(rf_out2),
        .op_valid(op_valid), .op_ready(op_ready), .op_opcode(op_opcode),
        .op_dst(op_dst), .op_a(op_a), .op_b(op_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // Register file device: registered reads, writes on set_enable. r0 holds junk when hardwired zero is on.
    logic [7:0] rf_mem [0:7];
    always @(posedge clock) begin
        if (reset_enable) begin
            for (int i = 0; i < 8; i++) rf_mem[i] <= 8'h00;
            if (ZERO_REG) rf_mem[0] <= 8'h5A;
            rf_out1 <= 8'h00;
            rf_out2 <= 8'h00;
        end else begin
            if (rf_set_enable) rf_mem[rf_num1] <= rf_set_val;
            if (rf_get_enable) begin
                rf_out1 <= rf_mem[rf_num1];
                rf_out2 <= rf_mem[rf_num2];
            end
        end
    end

    // Reference model: architectural registers plus cycles elapsed since the instruction was accepted.
    logic [7:0] ref_mem [0:7];
    int         ph = 0;
    logic [3:0] cur_opc;
    logic [2:0] cur_dst, cur_s1, cur_s2;
    logic [7:0] cur_a, cur_b;

    function automatic logic [7:0] ref_read(input logic [2:0] r);
        return (ZERO_REG && r == 3'd0) ? 8'h00 : ref_mem[r];
    endfunction

    always @(negedge clock) begin
        logic e_wbr, e_ir, e_set, e_get;
        e_wbr = (ph == 0) || (ph == 3);
        e_ir  = (ph == 0) && !wb_valid;
        e_set = e_wbr && wb_valid && !(ZERO_REG && wb_dst == 3'd0);
        e_get = (ph == 1);
        if (mon_en) begin
            check("wb_ready", wb_ready, e_wbr);
            check("instr_ready", instr_ready, e_ir);
            check("rf_set_enable", rf_set_enable, e_set);
            check("rf_get_enable", rf_get_enable, e_get);
            check("rf_num1", rf_num1, e_set ? wb_dst : (e_get ? cur_s1 : 3'd0));
            check("rf_num2", rf_num2, e_get ? cur_s2 : 3'd0);
            check("rf_set_val", rf_set_val, e_set ? wb_data : 8'h00);
            check("op_valid", op_valid, ph == 3);
            if (ph == 3) begin
                check("op_opcode", op_opcode, cur_opc);
                check("op_dst", op_dst, cur_dst);
                check("op_a", op_a, cur_a);
                check("op_b", op_b, cur_b);
            end
        end
        if (reset_enable) begin
            ph = 0;
            for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
        end else begin
            if (e_wbr && wb_valid && !(ZERO_REG && wb_dst == 3'd0)) ref_mem[wb_dst] = wb_data;
            case (ph)
                0: if (instr_valid && e_ir) begin
                    cur_opc = instr_opcode; cur_dst = instr_dst;
                    cur_s1  = instr_src1;   cur_s2  = instr_src2;
                    cur_a   = ref_read(instr_src1);
                    cur_b   = ref_read(instr_src2);
                    ph = 1;
                end
                1: ph = 2;
                2: ph = 3;
                default: if (op_ready) ph = 0;
            endcase
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_wb(input logic [2:0] d, input logic [7:0] v);
        wb_valid = 1'b1; wb_dst = d; wb_data = v;
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic set_instr(input logic [3:0] opc, input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
        instr_opcode = opc; instr_dst = d; instr_src1 = s1; instr_src2 = s2;
    endtask

    // Offers one instruction in IDLE, then counts cycles until op_valid (bounded).
    task automatic run_instr(input logic [3:0] opc, input logic [2:0] d, input logic [2:0] s1,
                             input logic [2:0] s2, output int lat);
        set_instr(opc, d, s1, s2);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        lat = 1;
        while (!op_valid && lat < 10) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        reset_enable = 1'b1;
        instr_valid = 1'b0; wb_valid = 1'b0; op_ready = 1'b0;
        set_instr(4'd0, 3'd0, 3'd0, 3'd0);
        wb_dst = 3'd0; wb_data = 8'h00;
        tick(); tick();
        reset_enable = 1'b0;
        mon_en = 1'b1;
        @(negedge clock);
        check("rst_op_valid", op_valid, 1'b0);
        check("rst_op_a", op_a, 8'h00);
        check("rst_op_opcode", op_opcode, 4'h0);
        check("rst_instr_ready", instr_ready, 1'b1);
        check("rst_wb_ready", wb_ready, 1'b1);

        // Writeback then dependent read through the register file.
        tick();
        send_wb(3'd3, 8'h2A);
        op_ready = 1'b1;
        run_instr(4'd5, 3'd1, 3'd3, 3'd3, lat);
        check("latency", lat, 3);
        check("basic_op_a", op_a, 8'h2A);
        check("basic_op_b", op_b, 8'h2A);
        check("basic_opcode", op_opcode, 4'd5);
        check("basic_dst", op_dst, 3'd1);
        tick();

        // Writeback wins over a simultaneous instruction.
        wb_valid = 1'b1; wb_dst = 3'd2; wb_data = 8'h33;
        set_instr(4'd7, 3'd4, 3'd2, 3'd3);
        instr_valid = 1'b1;
        @(negedge clock);
        check("prio_instr_ready", instr_ready, 1'b0);
        check("prio_set_enable", rf_set_enable, 1'b1);
        tick();
        wb_valid = 1'b0;
        @(negedge clock);
        check("prio_instr_ready_next", instr_ready, 1'b1);
        tick();
        instr_valid = 1'b0;
        lat = 1;
        while (!op_valid && lat < 10) begin tick(); lat++; end
        check("prio_latency", lat, 3);
        check("prio_op_a", op_a, 8'h33);
        check("prio_op_b", op_b, 8'h2A);
        tick();

        // ISSUE stall with a writeback to a source register.
        op_ready = 1'b0;
        run_instr(4'd3, 3'd5, 3'd3, 3'd2, lat);
        check("stall_latency", lat, 3);
        send_wb(3'd3, 8'h11);
        for (int i = 0; i < 4; i++) begin
            check("stall_op_a", op_a, 8'h2A);
            check("stall_op_valid", op_valid, 1'b1);
            tick();
        end
        op_ready = 1'b1;
        tick();
        check("stall_release", op_valid, 1'b0);
        run_instr(4'd1, 3'd6, 3'd3, 3'd0, lat);
        check("raw_op_a", op_a, 8'h11);
        tick();

        // Reset while in CAPTURE.
        set_instr(4'd2, 3'd2, 3'd2, 3'd3);
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        reset_enable = 1'b1;
        tick();
        reset_enable = 1'b0;
        @(negedge clock);
        check("midrst_op_valid", op_valid, 1'b0);
        check("midrst_instr_ready", instr_ready, 1'b1);
        check("midrst_op_a", op_a, 8'h00);
        tick();

        // Register 0 behaviour.
        wb_valid = 1'b1; wb_dst = 3'd0; wb_data = 8'hFF;
        @(negedge clock);
        check("r0_wb_ready", wb_ready, 1'b1);
        check("r0_set_enable", rf_set_enable, !ZERO_REG);
        tick();
        wb_valid = 1'b0;
        run_instr(4'd9, 3'd7, 3'd0, 3'd0, lat);
        check("r0_op_a", op_a, ZERO_REG ? 8'h00 : 8'hFF);
        tick();

        // Random traffic against the reference model.
        for (int i = 0; i < 1000; i++) begin
            wb_valid    = ($urandom % 3) == 0;
            wb_dst      = 3'($urandom);
            wb_data     = 8'($urandom);
            instr_valid = ($urandom % 2) == 0;
            set_instr(4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom));
            op_ready    = ($urandom % 2) == 0;
            check("no_dual_enable", rf_get_enable && rf_set_enable, 1'b0);
            tick();
        end
        wb_valid = 1'b0; instr_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Control stage directly upstream of the register file. Accepts decoded instructions and ALU writeback requests, and drives the register file's address, enable and write-data inputs so that a read and a write never share a cycle. It captures the two registered read operands and hands them, with opcode and destination, to the ALU over a valid/ready handshake. It is the only agent driving the register file's `num1`/`num2`/`set_val`/`get_enable`/`set_enable`.

## Interface
Parameters:
- `WORD_SIZE`, 8, operand/data width (shared CPU parameter set)
- `REG_ADDR_SIZE`, 3, register address width (8 registers)
- `OPCODE_SIZE`, 4, opcode width passed through to ALU

Ports:
- `clock`  in  1  single clock, all state on rising edge
- `reset_enable`  in  1  synchronous, active-high reset; also routed to the register file's own `reset_enable`
- `instr_valid`  in  1  instruction offered
- `instr_ready`  out  1  instruction accepted this cycle when both high
- `instr_opcode`  in  OPCODE_SIZE
- `instr_dst`, `instr_src1`, `instr_src2`  in  REG_ADDR_SIZE each
- `wb_valid`  in  1  writeback offered
- `wb_ready`  out  1  writeback accepted when both high
- `wb_dst`  in  REG_ADDR_SIZE;  `wb_data`  in  WORD_SIZE
- `rf_num1`, `rf_num2`  out  REG_ADDR_SIZE  register file addresses
- `rf_set_val`  out  WORD_SIZE
- `rf_get_enable`, `rf_set_enable`  out  1
- `rf_out1`, `rf_out2`  in  WORD_SIZE  registered read data from register file
- `op_valid`  out  1;  `op_ready`  in  1
- `op_opcode`  out  OPCODE_SIZE;  `op_dst`  out  REG_ADDR_SIZE;  `op_a`, `op_b`  out  WORD_SIZE

## Operation
- FSM states: IDLE, READ, CAPTURE, ISSUE.
- IDLE: `wb_ready`=1. If `wb_valid`: write cycle, `instr_ready`=0, stay IDLE. Else `instr_ready`=1; on `instr_valid` latch opcode/dst/src1/src2, go READ.
- READ: `rf_num1`=src1, `rf_num2`=src2, `rf_get_enable`=1, `wb_ready`=0, `instr_ready`=0 -> CAPTURE.
- CAPTURE: `wb_ready`=0; register `rf_out1`->`op_a`, `rf_out2`->`op_b` at end of cycle -> ISSUE.
- ISSUE: `op_valid`=1, `op_*` stable; `wb_ready`=1, `instr_ready`=0. On `op_valid && op_ready` -> IDLE.
- Write cycle (any state with `wb_ready`=1 and `wb_valid`=1): `rf_set_enable`=1, `rf_num1`=`wb_dst`, `rf_set_val`=`wb_data`.
- Writeback has priority over instruction acceptance in IDLE; never block writebacks for more than 2 consecutive cycles (READ, CAPTURE).
- `rf_get_enable` and `rf_set_enable` never both high. When neither is asserted, `rf_num1`/`rf_num2`/`rf_set_val` = 0.
- `rf_*`, `wb_ready`, `instr_ready` are combinational from state and inputs; `op_*` are registered.

## Timing
- Reset: state IDLE; `op_valid`=0, `op_opcode`/`op_dst`/`op_a`/`op_b`=0; latched fields cleared. Combinational outputs take their IDLE values in the first cycle after reset.
- Reset mid-operation (any state): next cycle is IDLE, in-flight instruction discarded, `op_valid` drops.
- Latency: instruction accepted at edge N -> READ in cycle N+1, CAPTURE N+2, `op_valid` high in cycle N+3. Minimum 4 cycles per instruction with `op_ready` held high.
- Writeback at edge N is visible to a read issued in a later READ cycle, so RAW through the register file needs no bypass.
- `op_valid` held with `op_*` unchanged until `op_ready`; writebacks during an ISSUE stall do not alter `op_a`/`op_b`.

## Configuration
- `OPSEQ_ZERO_REG_EN` defined: register 0 is hardwired zero. Writebacks with `wb_dst`=0 are accepted (`wb_ready` handshake completes) but `rf_set_enable` stays 0. Operands from src=0 are captured as 0 regardless of `rf_out1`/`rf_out2`.
- Undefined: register 0 is an ordinary register, written and read like the others.

## Test plan
- Reset, then wb r3=0x2A, then instr (opcode 5, dst 1, src1 3, src2 3) -> `rf_get_enable` pulses one cycle with num1=num2=3; `op_valid` three cycles after acceptance with `op_a`=`op_b`=0x2A, `op_opcode`=5, `op_dst`=1.
- `wb_valid` and `instr_valid` both high in IDLE -> writeback completes first, `instr_ready`=0 that cycle; instruction accepted the next cycle.
- Hold `op_ready`=0 for 5 cycles in ISSUE while wb r3=0x11 -> `op_a` stays 0x2A, write completes during ISSUE, `op_valid` stays high; release -> IDLE.
- Assert `reset_enable` during CAPTURE -> next cycle `op_valid`=0, state IDLE, `instr_ready`=1.
- Randomised wb/instr traffic for 1000 cycles -> `rf_get_enable && rf_set_enable` never true; `wb_ready`=0 only in READ/CAPTURE.
- With `OPSEQ_ZERO_REG_EN`: wb r0=0xFF -> handshake completes, `rf_set_enable`=0; instr src1=0 -> `op_a`=0. Without it: `op_a`=0xFF.
